// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Counter width for n steps, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder made of 1-bit full-adder cells.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout    = c[DIGIT];
  // Carry into the top bit of this digit; on the last digit it feeds signed overflow.
  assign msb_cin = c[DIGIT - 1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + cin over WIDTH bits, DIGIT bits per clock, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
  end

  sa_state_t         state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res_q;
  logic              c_q;
  logic [CW-1:0]     cnt;

  logic [DIGIT-1:0]       d_s;
  logic                   d_cout;
  logic                   d_msb_cin;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a       (a_q[DIGIT-1:0]),
    .b       (b_q[DIGIT-1:0]),
    .cin     (c_q),
    .s       (d_s),
    .cout    (d_cout),
    .msb_cin (d_msb_cin)
  );

  // New digit enters at the MSB end; the concatenation keeps the slice legal when DIGIT == WIDTH.
  assign res_cat  = {d_s, res_q};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

  // Handshake semantics: a transfer happens on a rising edge where valid && ready;
  // valid holds its payload until then, and ready never depends on valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            c_q      <= cin;
            res_q    <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          c_q   <= d_cout;
          res_q <= res_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= res_next;
            carry     <= d_cout;
            overflow  <= SIGNED ? (d_msb_cin ^ d_cout) : d_cout;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
